brcomp_arbiter: RTL
===================

# brcomp_arbiter

Sequencing and arbitration controller that shares the single 32-bit `brcomp` branch comparator between two requesters: port 0 is the integer branch unit and port 1 is the FP/auxiliary compare path. It accepts one compare operation at a time through valid/ready, drives the comparator from registered operands, and decodes `funct3` into a taken decision. It returns the result to the owning requester through a held valid/ready response. It sits between the execute-stage requesters and the `brcomp` instance.

## Interface
- FAIR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- reqN_valid_i  in  1  request valid on port N (N = 0, 1).
- reqN_ready_o  out  1  request accepted this cycle on port N.
- reqN_rs1_i, reqN_rs2_i  in  32  compare operands.
- reqN_funct3_i  in  3  branch funct3.
- rspN_valid_o  out  1  response valid to port N.
- rspN_ready_i  in  1  port N consumes the response.
- rspN_taken_o  out  1  branch condition true.
- rspN_less_o, rspN_equal_o  out  1  raw comparator flags.
- rspN_illegal_o  out  1  funct3 was 010 or 011.
- cmp_rs1_o, cmp_rs2_o  out  32  to comparator `rs1_data_i` / `rs2_data_i`.
- cmp_unsigned_o  out  1  to comparator `br_unsigned_i`.
- cmp_less_i, cmp_equal_i  in  1  from comparator `br_less_o` / `br_equal_o`.
- busy_o  out  1  high when the state is not IDLE.

## Operation
- Registers:
  - op_rs1_q, op_rs2_q (32 bits each)
  - f3_q
  - owner_q
  - prio_q (round-robin pointer)
  - result regs: less, equal, taken, illegal
  - state: IDLE, CMP, RSP
- cmp_rs1_o and cmp_rs2_o are op_rs1_q and op_rs2_q. cmp_unsigned_o is f3_q[1]. These are always driven and hold their last value outside CMP.
- Grant in IDLE:
  - If exactly one valid, that port wins.
  - If both valid, port prio_q wins; with FAIR=0, port 0 wins.
- reqN_ready_o = rst_ni && state==IDLE && grant==N. Ready is purely a function of state, prio_q and the valids, with no path from any rsp*_ready_i.
- IDLE, on a handshake: latch operands, funct3 and owner, then go to CMP. If FAIR=1, set prio_q to the other port.
- CMP: the comparator evaluates the registered operands. On the edge, capture cmp_less_i and cmp_equal_i, compute taken and illegal, then go to RSP.
- Decode (L = less, E = equal):
  - 000 → taken = E
  - 001 → taken = !E
  - 100 and 110 → taken = L
  - 101 and 111 → taken = !L
  - 010 and 011 → taken = 0, illegal = 1
- RSP: rsp[owner]_valid_o = 1; the other port's valid = 0.
  - Outputs stay stable until rsp[owner]_ready_i is sampled high.
  - Then go to IDLE; the other port may be granted in that same IDLE cycle.
- A requester that drops valid before being granted is ignored with no side effects. Grant is re-evaluated every IDLE cycle.

## Timing
- A handshake at edge T puts the state in CMP during T..T+1. rsp valid rises after edge T+1 and is visible in cycle T+1..T+2 (2-cycle latency).
- Minimum occupancy is 3 cycles per operation (IDLE, CMP, RSP). Peak throughput is 1 operation per 3 cycles when responses are consumed immediately.
- Response backpressure extends RSP indefinitely. No new request is accepted while in CMP or RSP.
- Reset values:
  - state IDLE, prio_q 0
  - all rsp*_valid_o 0; all result flags 0
  - cmp_rs1_o, cmp_rs2_o 0; cmp_unsigned_o 0
  - busy_o 0; req*_ready_o 0 while rst_ni is low
- Reset asserted mid-operation (CMP or RSP) drops the operation. No response is ever produced for it, and the next grant after release uses prio_q = 0.
- Simultaneous events: in RSP, a new reqN_valid_i is not accepted in the same cycle as the response handshake. It is accepted in the following IDLE cycle.

## Test plan
- Port 0 only: rs1=5, rs2=5, funct3=000 → req0_ready at accept, rsp0_valid 2 cycles later, taken=1, equal=1, rsp1_valid stays 0.
- Signed vs unsigned on port 1, rs1=32'hFFFF_FFFF, rs2=1:
  - funct3=100 → taken=1 (cmp_unsigned_o=0).
  - funct3=110 → taken=0 (cmp_unsigned_o=1).
- Contention, both ports valid continuously, FAIR=1 → grants alternate 0,1,0,1. With FAIR=0 → port 0 every time and port 1 starved.
- Backpressure: rsp0_ready_i held low 5 cycles with funct3=101 (rs1=3, rs2=7) → rsp0_valid and taken=0 stable all 5 cycles; req1 held valid is not accepted until the cycle after rsp0 handshake.
- Illegal funct3=011 → rsp illegal=1, taken=0, and the operation completes normally.
- rst_ni pulsed low while in RSP → rsp valid drops to 0 asynchronously, busy_o=0, and no stale response appears after release.

Source files
------------

// File: rtl/brcomp_arbiter.sv
// brcomp_arbiter: shares one brcomp comparator between two requesters,
// sequencing IDLE -> CMP -> RSP and decoding funct3 into a taken decision.
module brcomp_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_rs1_i,
  input  logic [31:0] req0_rs2_i,
  input  logic [2:0]  req0_funct3_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_rs1_i,
  input  logic [31:0] req1_rs2_i,
  input  logic [2:0]  req1_funct3_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic        rsp0_taken_o,
  output logic        rsp0_less_o,
  output logic        rsp0_equal_o,
  output logic        rsp0_illegal_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic        rsp1_taken_o,
  output logic        rsp1_less_o,
  output logic        rsp1_equal_o,
  output logic        rsp1_illegal_o,
  output logic [31:0] cmp_rs1_o,
  output logic [31:0] cmp_rs2_o,
  output logic        cmp_unsigned_o,
  input  logic        cmp_less_i,
  input  logic        cmp_equal_i,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;
  state_t      state;
  logic [31:0] op_rs1_q, op_rs2_q;
  logic [2:0]  f3_q;
  logic        owner_q, prio_q;
  logic        less_q, equal_q, taken_q, illegal_q;
  logic        rsp0_valid_q, rsp1_valid_q;
  logic        idle, gnt1, fire, taken_d;
  assign idle = state == IDLE;
  // Port 1 wins when alone, or on a tie when round-robin points at it.
  assign gnt1 = req1_valid_i && (!req0_valid_i || (FAIR && prio_q));
  assign fire = idle && (req0_valid_i || req1_valid_i);
  assign req0_ready_o = rst_ni && idle && req0_valid_i && !gnt1;
  assign req1_ready_o = rst_ni && idle && gnt1;
  // Bit 2 selects less vs equal, bit 0 inverts; 01x has no branch meaning.
  assign taken_d = f3_q[2] ? (cmp_less_i ^ f3_q[0]) : (!f3_q[1] && (cmp_equal_i ^ f3_q[0]));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      op_rs1_q     <= '0;
      op_rs2_q     <= '0;
      f3_q         <= '0;
      owner_q      <= 1'b0;
      prio_q       <= 1'b0;
      less_q       <= 1'b0;
      equal_q      <= 1'b0;
      taken_q      <= 1'b0;
      illegal_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          op_rs1_q <= gnt1 ? req1_rs1_i : req0_rs1_i;
          op_rs2_q <= gnt1 ? req1_rs2_i : req0_rs2_i;
          f3_q     <= gnt1 ? req1_funct3_i : req0_funct3_i;
          owner_q  <= gnt1;
          if (FAIR) prio_q <= !gnt1;
          state    <= CMP;
        end
        CMP: begin
          less_q       <= cmp_less_i;
          equal_q      <= cmp_equal_i;
          taken_q      <= taken_d;
          illegal_q    <= !f3_q[2] && f3_q[1];
          rsp0_valid_q <= !owner_q;
          rsp1_valid_q <= owner_q;
          state        <= RSP;
        end
        RSP: if (owner_q ? rsp1_ready_i : rsp0_ready_i) begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign cmp_rs1_o      = op_rs1_q;
  assign cmp_rs2_o      = op_rs2_q;
  assign cmp_unsigned_o = f3_q[1];
  assign busy_o         = !idle;
  assign rsp0_valid_o   = rsp0_valid_q;
  assign rsp1_valid_o   = rsp1_valid_q;
  assign rsp0_taken_o   = taken_q;
  assign rsp1_taken_o   = taken_q;
  assign rsp0_less_o    = less_q;
  assign rsp1_less_o    = less_q;
  assign rsp0_equal_o   = equal_q;
  assign rsp1_equal_o   = equal_q;
  assign rsp0_illegal_o = illegal_q;
  assign rsp1_illegal_o = illegal_q;
endmodule
